// File: rtl/mips_int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS external-interrupt controller: controller
// state enumeration, exception cause code, default handler vector, data width
// and a small output-gating helper.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int unsigned XLEN                 = 32;
    localparam logic [4:0]  EXC_INT              = 5'd0;
    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_0024;
    localparam int unsigned SYNC_STAGES_DEFAULT  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        VECTOR    = 2'd2,
        HANDLER   = 2'd3
    } int_state_e;

    // Forces a data bus to zero whenever its qualifying strobe is low, so
    // idle buses never carry stale addresses.
    function automatic logic [XLEN-1:0] gate32(input logic en, input logic [XLEN-1:0] value);
        logic [XLEN-1:0] result;
        if (en) begin
            result = value;
        end else begin
            result = {XLEN{1'b0}};
        end
        return result;
    endfunction

endpackage

// File: rtl/mips_int_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_int_ctrl_if
// Pipeline-side signal bundle of the interrupt controller.
//   i_int_enable : status IE bit from coprocessor 0
//   i_stall      : pipeline stalled this cycle
//   i_ex_valid   : EX stage holds a real (non-bubble) instruction
//   i_ex_pc      : PC of the instruction in EX
//   i_eret       : eret retiring this cycle
//   o_flush      : squash IF, ID and EX
//   o_pc_sel     : fetch PC := o_pc_target
//   o_pc_target  : redirect address
//   o_epc_we     : EPC write strobe
//   o_epc        : value to write into EPC
//   o_cause_we   : cause write strobe (cause code EXC_INT)
//   o_in_handler : interrupt handler active
// Modport slave is the controller, modport master is the pipeline.
// -----------------------------------------------------------------------------
interface mips_int_ctrl_if;
    import mips_pkg::*;

    logic            i_int_enable;
    logic            i_stall;
    logic            i_ex_valid;
    logic [XLEN-1:0] i_ex_pc;
    logic            i_eret;
    logic            o_flush;
    logic            o_pc_sel;
    logic [XLEN-1:0] o_pc_target;
    logic            o_epc_we;
    logic [XLEN-1:0] o_epc;
    logic            o_cause_we;
    logic            o_in_handler;

    modport slave (
        input  i_int_enable, i_stall, i_ex_valid, i_ex_pc, i_eret,
        output o_flush, o_pc_sel, o_pc_target, o_epc_we, o_epc,
               o_cause_we, o_in_handler
    );

    modport master (
        output i_int_enable, i_stall, i_ex_valid, i_ex_pc, i_eret,
        input  o_flush, o_pc_sel, o_pc_target, o_epc_we, o_epc,
               o_cause_we, o_in_handler
    );

endinterface

// File: rtl/mips_int_ctrl_sync.sv
// -----------------------------------------------------------------------------
// mips_sync
// DEPTH-flop synchronizer bringing an asynchronous level into the i_clk domain.
//   i_clk : clock
//   i_rst : synchronous active-high reset, clears every stage
//   i_d   : asynchronous input level
//   o_q   : synchronized level (last stage)
// -----------------------------------------------------------------------------
module mips_sync #(
    parameter int unsigned DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_stage;

    // Shift chain: stage 0 samples the raw input, later stages resolve metastability.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stage <= {DEPTH{1'b0}};
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/mips_int_ctrl.sv
// -----------------------------------------------------------------------------
// mips_int_ctrl
// External-interrupt controller for a 5-stage MIPS pipeline. Synchronizes the
// interrupt request, waits for a valid unstalled instruction in EX to become
// the restart point, flushes the front of the pipe, vectors to the handler and
// returns through EPC on eret.
//   i_clk                : sole clock, rising edge
//   i_rst                : synchronous active-high reset
//   i_external_interrupt : asynchronous level-sensitive request
//   bus (slave)          : pipeline inputs and controller strobes/addresses
// Parameters: HANDLER_ADDR (handler PC), SYNC_STAGES (synchronizer depth).
// -----------------------------------------------------------------------------
module mips_int_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_external_interrupt,
    mips_int_ctrl_if.slave bus
);

    int_state_e      r_state;
    int_state_e      w_state_next;
    logic [XLEN-1:0] r_epc;
    logic            w_irq_sync;
    logic            w_take_slot;
    logic            w_epc_we;
    logic            w_pc_sel;
    logic            w_in_handler;
    logic [XLEN-1:0] w_target_raw;

    mips_sync #(
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_external_interrupt),
        .o_q   (w_irq_sync)
    );

    // The restart slot is the first real instruction in EX that is not held.
    assign w_take_slot = bus.i_ex_valid & ~bus.i_stall;

    // State register; entering WAIT_SLOT is itself the request latch, so the
    // input level no longer matters once the sequence has started.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // EPC holds the restart PC captured in the slot cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_epc <= {XLEN{1'b0}};
        end else if (w_epc_we) begin
            r_epc <= bus.i_ex_pc;
        end else begin
            r_epc <= r_epc;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_state_next = r_state;
        w_epc_we     = 1'b0;
        w_pc_sel     = 1'b0;
        w_in_handler = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_irq_sync && bus.i_int_enable) begin
                    w_state_next = WAIT_SLOT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WAIT_SLOT: begin
                if (!bus.i_int_enable) begin
                    w_state_next = IDLE;
                end else if (w_take_slot) begin
                    w_epc_we     = 1'b1;
                    w_state_next = VECTOR;
                end else begin
                    w_state_next = WAIT_SLOT;
                end
            end
            VECTOR: begin
                w_pc_sel = 1'b1;
                if (!bus.i_stall) begin
                    w_state_next = HANDLER;
                end else begin
                    w_state_next = VECTOR;
                end
            end
            HANDLER: begin
                w_in_handler = 1'b1;
                // eret has priority; any pending level is re-sampled from IDLE.
                if (bus.i_eret) begin
                    w_pc_sel     = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = HANDLER;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Only two redirect sources exist: the handler vector or the saved EPC.
    always_comb begin
        if (r_state == HANDLER) begin
            w_target_raw = r_epc;
        end else begin
            w_target_raw = HANDLER_ADDR;
        end
    end

    // The slot cycle also flushes the front end and records the cause.
    assign bus.o_flush      = w_epc_we;
    assign bus.o_cause_we   = w_epc_we;
    assign bus.o_epc_we     = w_epc_we;
    assign bus.o_epc        = gate32(w_epc_we, bus.i_ex_pc);
    assign bus.o_pc_sel     = w_pc_sel;
    assign bus.o_pc_target  = gate32(w_pc_sel, w_target_raw);
    assign bus.o_in_handler = w_in_handler;

endmodule

// File: tb/tb_mips_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_int_ctrl
// Directed scenarios followed by random traffic, every cycle compared against
// a rule-level reference model of the interrupt protocol.
// -----------------------------------------------------------------------------
module tb_mips_int_ctrl;

    localparam int          SYNC  = 2;
    localparam logic [31:0] HADDR = 32'h0000_0024;

    logic clk = 1'b0;
    logic rst;
    logic irq;

    always #5 clk = ~clk;

    mips_int_ctrl_if bus();

    mips_int_ctrl #(
        .HANDLER_ADDR (HADDR),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_external_interrupt (irq),
        .bus                  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: request seen after SYNC edges; protocol phases as flags.
    bit          m_line [SYNC];
    bit          m_waiting;
    bit          m_redirecting;
    bit          m_handling;
    logic [31:0] m_epc;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit          take;
        bit          ret;
        logic [31:0] tgt;
        take = m_waiting && bus.i_int_enable && bus.i_ex_valid && !bus.i_stall;
        ret  = m_handling && bus.i_eret;
        tgt  = m_redirecting ? HADDR : (ret ? m_epc : 32'h0);
        chk1 ("flush",      bus.o_flush,      take);
        chk1 ("epc_we",     bus.o_epc_we,     take);
        chk1 ("cause_we",   bus.o_cause_we,   take);
        chk32("epc",        bus.o_epc,        take ? bus.i_ex_pc : 32'h0);
        chk1 ("pc_sel",     bus.o_pc_sel,     m_redirecting || ret);
        chk32("pc_target",  bus.o_pc_target,  tgt);
        chk1 ("in_handler", bus.o_in_handler, m_handling);
    endtask

    task automatic model_edge();
        bit seen;
        seen = m_line[SYNC-1];
        if (rst) begin
            m_waiting     = 1'b0;
            m_redirecting = 1'b0;
            m_handling    = 1'b0;
            m_epc         = 32'h0;
            for (int i = 0; i < SYNC; i++) m_line[i] = 1'b0;
        end else begin
            if (m_waiting) begin
                if (!bus.i_int_enable) begin
                    m_waiting = 1'b0;
                end else if (bus.i_ex_valid && !bus.i_stall) begin
                    m_waiting     = 1'b0;
                    m_redirecting = 1'b1;
                    m_epc         = bus.i_ex_pc;
                end
            end else if (m_redirecting) begin
                if (!bus.i_stall) begin
                    m_redirecting = 1'b0;
                    m_handling    = 1'b1;
                end
            end else if (m_handling) begin
                if (bus.i_eret) m_handling = 1'b0;
            end else if (seen && bus.i_int_enable) begin
                m_waiting = 1'b1;
            end
            for (int i = SYNC - 1; i > 0; i--) m_line[i] = m_line[i-1];
            m_line[0] = irq;
        end
    endtask

    // One clock: compare mid-cycle, advance model at the edge, return just after.
    task automatic step();
        #4;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        irq              = 1'b0;
        bus.i_int_enable = 1'b0;
        bus.i_stall      = 1'b0;
        bus.i_ex_valid   = 1'b0;
        bus.i_ex_pc      = 32'h0;
        bus.i_eret       = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        step();
        rst = 1'b0;
        #1;
        chk1 ("rst_pc_sel",     bus.o_pc_sel,     1'b0);
        chk1 ("rst_epc_we",     bus.o_epc_we,     1'b0);
        chk1 ("rst_in_handler", bus.o_in_handler, 1'b0);
        chk32("rst_target",     bus.o_pc_target,  32'h0);

        // Single-cycle pulse, no stall: strobe at 3, vector at 4, handler at 5.
        bus.i_int_enable = 1'b1;
        bus.i_ex_valid   = 1'b1;
        bus.i_ex_pc      = 32'h10;
        irq              = 1'b1;
        step();
        irq = 1'b0;
        step();
        step();
        #1;
        chk1 ("c3_epc_we",   bus.o_epc_we,   1'b1);
        chk1 ("c3_cause_we", bus.o_cause_we, 1'b1);
        chk1 ("c3_flush",    bus.o_flush,    1'b1);
        chk32("c3_epc",      bus.o_epc,      32'h10);
        step();
        #1;
        chk1 ("c4_pc_sel", bus.o_pc_sel,      1'b1);
        chk32("c4_target", bus.o_pc_target,   32'h24);
        step();
        #1;
        chk1 ("c5_in_handler", bus.o_in_handler, 1'b1);
        chk1 ("c5_pc_sel",     bus.o_pc_sel,     1'b0);

        // Level held inside the handler must not nest.
        irq = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            chk1("nest_epc_we", bus.o_epc_we,     1'b0);
            chk1("nest_in_h",   bus.o_in_handler, 1'b1);
        end
        bus.i_eret = 1'b1;
        #1;
        chk1 ("eret_pc_sel", bus.o_pc_sel,    1'b1);
        chk32("eret_target", bus.o_pc_target, 32'h10);
        step();
        bus.i_eret  = 1'b0;
        bus.i_ex_pc = 32'h20;
        #1;
        chk1("post_eret_idle_h",  bus.o_in_handler, 1'b0);
        chk1("post_eret_idle_we", bus.o_epc_we,     1'b0);
        step();
        #1;
        chk1 ("reenter_epc_we", bus.o_epc_we, 1'b1);
        chk32("reenter_epc",    bus.o_epc,    32'h20);
        irq = 1'b0;
        step();
        step();
        bus.i_eret = 1'b1;
        #1;
        chk32("eret2_target", bus.o_pc_target, 32'h20);
        step();
        bus.i_eret = 1'b0;

        // EX bubbles in WAIT_SLOT, then stall held three cycles in VECTOR.
        bus.i_ex_valid = 1'b0;
        bus.i_ex_pc    = 32'h30;
        irq            = 1'b1;
        step();
        irq = 1'b0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1("bubble_epc_we", bus.o_epc_we, 1'b0);
            step();
        end
        bus.i_ex_valid = 1'b1;
        bus.i_ex_pc    = 32'h40;
        #1;
        chk1 ("bubble_take",     bus.o_epc_we, 1'b1);
        chk32("bubble_epc",      bus.o_epc,    32'h40);
        step();
        for (int k = 0; k < 4; k++) begin
            bus.i_stall = (k < 3);
            #1;
            chk1 ("stall_pc_sel", bus.o_pc_sel,      1'b1);
            chk32("stall_target", bus.o_pc_target,   32'h24);
            chk1 ("stall_not_h",  bus.o_in_handler,  1'b0);
            step();
        end
        #1;
        chk1("stall_then_h", bus.o_in_handler, 1'b1);
        chk1("stall_done",   bus.o_pc_sel,     1'b0);
        bus.i_eret = 1'b1;
        #1;
        chk32("eret3_target", bus.o_pc_target, 32'h40);
        step();
        bus.i_eret = 1'b0;

        // IE=0 blocks entry; IE dropped in WAIT_SLOT abandons the interrupt.
        bus.i_int_enable = 1'b0;
        irq              = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1("ie0_epc_we", bus.o_epc_we, 1'b0);
            chk1("ie0_pc_sel", bus.o_pc_sel, 1'b0);
            step();
        end
        bus.i_int_enable = 1'b1;
        step();
        bus.i_int_enable = 1'b0;
        irq              = 1'b0;
        #1;
        chk1("ie_drop_epc_we", bus.o_epc_we, 1'b0);
        for (int k = 0; k < 4; k++) step();
        bus.i_int_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk1("abandon_epc_we", bus.o_epc_we, 1'b0);
            step();
        end

        // Reset taken while vectoring.
        bus.i_ex_pc = 32'h50;
        irq         = 1'b1;
        step();
        irq = 1'b0;
        step();
        step();
        step();
        #1;
        chk1("pre_rst_vector", bus.o_pc_sel, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk1 ("vrst_pc_sel",  bus.o_pc_sel,      1'b0);
        chk32("vrst_target",  bus.o_pc_target,   32'h0);
        chk1 ("vrst_in_h",    bus.o_in_handler,  1'b0);
        chk1 ("vrst_epc_we",  bus.o_epc_we,      1'b0);
        chk32("vrst_epc",     bus.o_epc,         32'h0);
        chk1 ("vrst_flush",   bus.o_flush,       1'b0);
        for (int k = 0; k < 4; k++) step();

        // Random traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 9) == 0) irq = ~irq;
            bus.i_int_enable = ($urandom_range(0, 7) != 0);
            bus.i_stall      = ($urandom_range(0, 3) == 0);
            bus.i_ex_valid   = ($urandom_range(0, 3) != 0);
            bus.i_ex_pc      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bus.i_eret       = ($urandom_range(0, 5) == 0);
            rst              = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_int_ctrl.md
MIPS_INT_CTRL -- requirements
Module: mips_int_ctrl

Interface
REQ-001 Parameter HANDLER_ADDR, default 32'h24: PC of the interrupt handler.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth for the external interrupt.
REQ-003 Port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port i_rst  input  1  reset; synchronous, active-high.
REQ-005 Port i_external_interrupt  input  1  asynchronous, level-sensitive interrupt request.
REQ-006 Port i_int_enable  input  1  status IE bit from coprocessor 0.
REQ-007 Port i_stall  input  1  pipeline stalled this cycle.
REQ-008 Port i_ex_valid  input  1  EX stage holds a valid, non-bubble instruction.
REQ-009 Port i_ex_pc  input  32  PC of the instruction in EX.
REQ-010 Port i_eret  input  1  eret retiring this cycle.
REQ-011 Port o_flush  output  1  squash the IF, ID and EX stages.
REQ-012 Port o_pc_sel  output  1  fetch PC := o_pc_target.
REQ-013 Port o_pc_target  output  32  redirect address.
REQ-014 Port o_epc_we  output  1  EPC write strobe.
REQ-015 Port o_epc  output  32  value to write into EPC.
REQ-016 Port o_cause_we  output  1  cause write strobe; cause code fixed to EXC_INT.
REQ-017 Port o_in_handler  output  1  interrupt handler is active.

Function
REQ-018 The block SHALL pass i_external_interrupt through a SYNC_STAGES-flop synchronizer before any other use.
REQ-019 The FSM SHALL have states IDLE, WAIT_SLOT, VECTOR and HANDLER.
REQ-020 IDLE: if synchronized request=1 and i_int_enable=1 -> WAIT_SLOT. Request latched, so later deassertion of the input is ignored.
REQ-021 WAIT_SLOT: if i_int_enable=0 -> IDLE, interrupt abandoned.
REQ-022 WAIT_SLOT: else if i_ex_valid=1 and i_stall=0 -> single cycle with o_epc_we=o_cause_we=o_flush=1 and o_epc=i_ex_pc; EPC register loaded; -> VECTOR.
REQ-023 VECTOR: o_pc_sel=1, o_pc_target=HANDLER_ADDR; held while i_stall=1; on first cycle with i_stall=0 -> HANDLER.
REQ-024 HANDLER: o_in_handler=1; the interrupt input is ignored.
REQ-025 HANDLER: on i_eret=1 -> one cycle o_pc_sel=1, o_pc_target=EPC register; -> IDLE.
REQ-026 i_eret outside HANDLER SHALL be ignored by this block.
REQ-027 Interrupt and i_eret in the same HANDLER cycle: eret wins. A level still high afterwards re-enters WAIT_SLOT no earlier than the cycle after IDLE.
REQ-028 Outputs not named active in a state SHALL be 0; o_pc_target and o_epc SHALL be 0 when their strobes are low.
REQ-029 Minimum interrupt-to-redirect latency with no stall and EX valid: SYNC_STAGES+2 cycles from the input rising edge to o_pc_sel=1.

Reset
REQ-030 i_rst=1 at a clock edge SHALL force state IDLE, clear the synchronizer, latch and EPC register, and drive all outputs to 0 in the next cycle, including mid-sequence or in HANDLER.
REQ-031 The first cycle after reset release SHALL be able to sample the synchronizer; no extra dead cycles.

Structure
REQ-032 Package mips_pkg SHALL hold the state enumeration, EXC_INT=5'd0 and the HANDLER_ADDR default constant.
REQ-033 The synchronizer SHALL be a separate sub-module, mips_sync, with a depth parameter.
REQ-034 Target size: 120-250 lines of RTL; the EPC register lives in this block, and the coprocessor 0 copy is written from o_epc.

Verification
REQ-035 Pulse interrupt, IE=1, EX valid, PC=0x10, no stall -> EPC=0x10 strobe at cycle 3, o_pc_sel with target 0x24 at cycle 4, o_in_handler=1 at cycle 5.
REQ-036 Hold i_stall=1 for 3 cycles while in VECTOR -> o_pc_sel stays 1 with target 0x24 for 4 cycles, then HANDLER.
REQ-037 In HANDLER, i_eret with interrupt high -> redirect to 0x10, IDLE, then a new sequence starts; no nested entry during HANDLER.
REQ-038 IE=0 with interrupt high -> no strobes; IE dropped during WAIT_SLOT -> returns to IDLE with no EPC write.
REQ-039 i_rst asserted in VECTOR -> next cycle all outputs 0 and state IDLE; EPC reads 0.
REQ-040 EX bubbles (i_ex_valid=0) for 4 cycles -> EPC captures the first valid PC after the bubbles.
